// File: rtl/ysyx_22041405_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22041405_wb_arbiter
//
// Shares the single register-file write port between the EXU (ALU results)
// and the LSU (load data). The two sources are arbitrated round-robin. The
// winner goes through a one-stage registered write pipe that drives the
// regsfile write port. The regsfile port has no write enable, so an idle
// cycle is encoded as waddr = 0, because x0 writes are discarded anyway.
//
// A per-register busy scoreboard is also kept. A bit is set when an
// instruction issues with that destination and cleared when its write
// commits. The IDU uses issue_ready to stall on RAW/WAW hazards.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active-low
//   issue_valid  IDU presents an instruction for issue
//   issue_rd     destination register of the issuing instruction
//   issue_rs1    source register 1 of the issuing instruction
//   issue_rs2    source register 2 of the issuing instruction
//   issue_ready  1 = no hazard; the issue fires on valid & ready
//   exu_valid    EXU writeback request
//   exu_ready    EXU request accepted this cycle
//   exu_rd       EXU destination register
//   exu_wdata    EXU result
//   lsu_valid    LSU writeback request
//   lsu_ready    LSU request accepted this cycle
//   lsu_rd       LSU destination register
//   lsu_wdata    LSU load data
//   rf_waddr     regsfile write address (registered, 0 = idle)
//   rf_wdata     regsfile write data (registered)
// ----------------------------------------------------------------------------
module ysyx_22041405_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    output logic                  issue_ready,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  grant_exu_s;
    logic                  grant_lsu_s;
    logic                  prio_exu_r;   // 1 = EXU wins when both request
    logic [NREG-1:0]       busy_r;
    logic [NREG-1:0]       busy_nxt_s;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  issue_ready_s;
    logic                  issue_fire_s;

    // Round-robin grant; nothing is granted while reset is asserted.
    always_comb begin
        grant_exu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (!rst) begin
            grant_exu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end else if (exu_valid && (!lsu_valid || prio_exu_r)) begin
            grant_exu_s = 1'b1;
        end else if (lsu_valid) begin
            grant_lsu_s = 1'b1;
        end else begin
            grant_exu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    // Hazard check against the current busy bits. A commit that is in flight
    // in this cycle does not bypass the check. busy_r[0] is always 0, so x0
    // operands never stall.
    always_comb begin
        issue_ready_s = rst & ~busy_r[issue_rs1] & ~busy_r[issue_rs2] & ~busy_r[issue_rd];
        issue_fire_s  = issue_valid & issue_ready_s;
    end

    // Scoreboard next state. The commit clear is applied first so that a
    // same-edge issue to the same rd (a new producer) wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (waddr_r != {ADDR_WIDTH{1'b0}}) begin
            busy_nxt_s[waddr_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (issue_fire_s && (issue_rd != {ADDR_WIDTH{1'b0}})) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Write pipe and round-robin pointer. A pipe entry pending at reset is
    // dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waddr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            prio_exu_r <= 1'b1;
        end else if (grant_exu_s) begin
            waddr_r    <= exu_rd;
            wdata_r    <= exu_wdata;
            prio_exu_r <= 1'b0;
        end else if (grant_lsu_s) begin
            waddr_r    <= lsu_rd;
            wdata_r    <= lsu_wdata;
            prio_exu_r <= 1'b1;
        end else begin
            waddr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            prio_exu_r <= prio_exu_r;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign exu_ready   = grant_exu_s;
    assign lsu_ready   = grant_lsu_s;
    assign issue_ready = issue_ready_s;
    assign rf_waddr    = waddr_r;
    assign rf_wdata    = wdata_r;

endmodule

// File: tb/tb_ysyx_22041405_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041405_wb_arbiter
//
// Directed bench with a write scoreboard. The stimulus pushes the
// hand-computed (waddr, wdata) of every accepted transfer. A negedge monitor
// pops an entry and compares it whenever rf_waddr is non-zero. A small
// regsfile model follows rf_waddr/rf_wdata so that committed values can be
// checked.
// ----------------------------------------------------------------------------
module tb_ysyx_22041405_wb_arbiter;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_ready;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_wdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] regs [32];
    int          checks;
    int          errors;

    ysyx_22041405_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_wdata   (exu_wdata),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_wdata   (lsu_wdata),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Regsfile model: commits on posedge, discards x0, writes nothing in reset.
    always @(posedge clk) begin
        if (rst === 1'b1 && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Monitor: every non-idle write-port cycle must match the next expected write.
    always @(negedge clk) begin
        if (rf_waddr !== 5'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h, expected idle",
                         rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_addr", 32'(rf_waddr), 32'(mon_e.a));
                chk("wb_data", rf_wdata, mon_e.d);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        // Test 1: reset held for two cycles with requests and hazards present.
        rst         = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd31;
        issue_rs1   = 5'd5;
        issue_rs2   = 5'd9;
        exu_valid   = 1'b1;
        exu_rd      = 5'd1;
        exu_wdata   = 32'h11111111;
        lsu_valid   = 1'b1;
        lsu_rd      = 5'd2;
        lsu_wdata   = 32'h22222222;
        step();
        step();
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_exu_ready", 32'(exu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst_issue_ready_in_rst", 32'(issue_ready), 32'd0);
        exu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
        rst         = 1'b1;
        #1;
        chk("rst_issue_ready_clean", 32'(issue_ready), 32'd1);

        // Test 2: RAW stall on rd=5 that clears one cycle after the commit edge.
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        #1;
        chk("t2_issue_rd5", 32'(issue_ready), 32'd1);
        step();
        issue_rs1 = 5'd5;
        issue_rd  = 5'd6;
        exu_valid = 1'b1;
        exu_rd    = 5'd5;
        exu_wdata = 32'hDEADBEEF;
        #1;
        chk("t2_stall_rs1", 32'(issue_ready), 32'd0);
        chk("t2_exu_ready", 32'(exu_ready), 32'd1);
        push(5'd5, 32'hDEADBEEF);
        step();
        exu_valid = 1'b0;
        #1;
        chk("t2_stall_during_commit", 32'(issue_ready), 32'd0);
        step();
        chk("t2_stall_cleared", 32'(issue_ready), 32'd1);
        chk("t2_reg5", regs[5], 32'hDEADBEEF);
        issue_valid = 1'b0;

        // Test 3: both held valid after reset -> EXU, LSU, EXU, LSU.
        rst = 1'b0;
        step();
        rst       = 1'b1;
        exu_valid = 1'b1;
        exu_rd    = 5'd3;
        exu_wdata = 32'h33333333;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_wdata = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_exu_grant", 32'(exu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_lsu_grant", 32'(lsu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) push(5'd3, 32'h33333333);
            else            push(5'd4, 32'h44444444);
            step();
        end
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();

        // Test 4: commit of rd=7 (not busy) on the same edge as issue rd=7 -> set wins.
        exu_valid = 1'b1;
        exu_rd    = 5'd7;
        exu_wdata = 32'h00000077;
        #1;
        chk("t4_exu_ready", 32'(exu_ready), 32'd1);
        push(5'd7, 32'h00000077);
        step();
        exu_valid   = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        #1;
        chk("t4_issue_rd7_free", 32'(issue_ready), 32'd1);
        step();
        chk("t4_set_wins", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        exu_valid   = 1'b1;
        exu_wdata   = 32'h00000700;
        #1;
        chk("t4_exu_ready2", 32'(exu_ready), 32'd1);
        push(5'd7, 32'h00000700);
        step();
        exu_valid = 1'b0;
        step();
        chk("t4_rd7_released", 32'(issue_ready), 32'd1);

        // Test 5: x0 destination never stalls and its write is idle-encoded.
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("t5_issue_x0", 32'(issue_ready), 32'd1);
        step();
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_wdata = 32'h00001234;
        #1;
        chk("t5_issue_x0_again", 32'(issue_ready), 32'd1);
        chk("t5_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t5_exu_idle", 32'(exu_ready), 32'd0);
        step();
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
        chk("t5_waddr_x0", 32'(rf_waddr), 32'd0);
        step();
        chk("t5_reg0", regs[0], 32'd0);

        // Last grant was LSU, so EXU wins the next contention.
        exu_valid = 1'b1;
        exu_rd    = 5'd8;
        exu_wdata = 32'h88888888;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_wdata = 32'h99999999;
        #1;
        chk("rr_exu_first", 32'(exu_ready), 32'd1);
        chk("rr_lsu_wait", 32'(lsu_ready), 32'd0);
        push(5'd8, 32'h88888888);
        step();
        exu_valid = 1'b0;
        #1;
        chk("rr_lsu_next", 32'(lsu_ready), 32'd1);
        push(5'd9, 32'h99999999);
        step();
        lsu_valid = 1'b0;
        step();

        // Test 6: reset on the commit edge drops the write and clears busy.
        issue_valid = 1'b1;
        issue_rd    = 5'd11;
        #1;
        chk("t6_issue_rd11", 32'(issue_ready), 32'd1);
        step();
        issue_rd = 5'd10;
        #1;
        chk("t6_issue_rd10", 32'(issue_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        exu_valid   = 1'b1;
        exu_rd      = 5'd10;
        exu_wdata   = 32'h0000AAAA;
        #1;
        chk("t6_exu_ready", 32'(exu_ready), 32'd1);
        push(5'd10, 32'h0000AAAA);
        step();
        exu_valid = 1'b0;
        rst       = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_waddr_after_rst", 32'(rf_waddr), 32'd0);
        chk("t6_wdata_after_rst", rf_wdata, 32'd0);
        chk("t6_reg10_not_written", regs[10], 32'd0);
        issue_rs1 = 5'd10;
        issue_rs2 = 5'd11;
        issue_rd  = 5'd11;
        #1;
        chk("t6_busy_cleared", 32'(issue_ready), 32'd1);

        step();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
